// File: rtl/dvid2vga_channel.sv
// One TMDS channel receive decoder: finds the symbol boundary in the deserialized
// stream by bit-slip and decodes each 10-bit symbol to a pixel byte or control pair.
module dvid2vga_channel #(
    parameter int unsigned C_lock_run      = 16,
    parameter int unsigned C_search_cycles = 4096
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] in_raw,
    output logic [7:0] out_data,
    output logic [1:0] out_c,
    output logic       out_de,
    output logic       out_locked,
    output logic [3:0] out_offset
);

    localparam int unsigned RUN_W   = $clog2(C_lock_run + 1);
    localparam int unsigned TIMER_W = $clog2(C_search_cycles);
    localparam int unsigned OFF_MAX = 9;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [9:0]           raw_d;
    logic [9:0]           sym;
    logic [19:0]          hist;
    logic [9:0]           sym_next;
    logic [3:0]           offset;
    logic [RUN_W-1:0]     run;
    logic [RUN_W-1:0]     run_inc;
    logic [TIMER_W-1:0]   timer;

    logic                 is_ctrl;
    logic [1:0]           ctrl_val;
    logic [7:0]           d_unmasked;
    logic [7:0]           dec;

    logic                 lock_hit;
    logic                 timer_exp;
    logic                 slip;
    logic                 timer_clr;

    // Two consecutive raw words give every possible 10-bit window for offsets 0..9.
    always_comb begin
        hist     = {in_raw, raw_d};
        sym_next = hist[{1'b0, offset} +: 10];
    end

    // Control token recognition on the currently framed symbol.
    always_comb begin
        is_ctrl  = 1'b1;
        ctrl_val = 2'b00;
        case (sym)
            10'h354: ctrl_val = 2'b00;
            10'h0AB: ctrl_val = 2'b01;
            10'h154: ctrl_val = 2'b10;
            10'h2AB: ctrl_val = 2'b11;
            default: is_ctrl  = 1'b0;
        endcase
    end

    // TMDS data decode: undo the optional inversion, then the XOR/XNOR chain.
    always_comb begin
        d_unmasked = sym[9] ? ~sym[7:0] : sym[7:0];
        dec        = '0;
        dec[0]     = d_unmasked[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym[8] ? (d_unmasked[i] ^ d_unmasked[i-1])
                            : ~(d_unmasked[i] ^ d_unmasked[i-1]);
        end
    end

    // Run of consecutive control tokens, saturating at the lock threshold.
    always_comb begin
        run_inc = '0;
        if (is_ctrl) begin
            run_inc = (run == RUN_W'(C_lock_run)) ? run : run + RUN_W'(1);
        end
        lock_hit  = (run_inc == RUN_W'(C_lock_run));
        timer_exp = (timer == TIMER_W'(C_search_cycles - 1));
    end

    // FSM: state register.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            SEARCH: begin
                if (lock_hit) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (!is_ctrl && timer_exp) begin
                    state_next = SEARCH;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // FSM: control outputs. Lock beats a simultaneous search timeout.
    always_comb begin
        slip      = 1'b0;
        timer_clr = 1'b0;
        case (state)
            SEARCH: begin
                if (lock_hit) begin
                    timer_clr = 1'b1;
                end else if (timer_exp) begin
                    slip      = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            LOCKED: begin
                if (is_ctrl) begin
                    timer_clr = 1'b1;
                end else if (timer_exp) begin
                    slip      = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            default: begin
                slip      = 1'b0;
                timer_clr = 1'b0;
            end
        endcase
    end

    // Alignment bookkeeping: offset, run counter and watchdog timer.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            offset <= '0;
            run    <= '0;
            timer  <= '0;
        end else begin
            run   <= slip ? '0 : run_inc;
            timer <= timer_clr ? '0 : timer + TIMER_W'(1);
            if (slip) begin
                offset <= (offset == 4'(OFF_MAX)) ? 4'd0 : offset + 4'd1;
            end
        end
    end

    // Datapath pipeline and registered decode outputs.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            raw_d      <= '0;
            sym        <= '0;
            out_data   <= '0;
            out_c      <= '0;
            out_de     <= 1'b0;
            out_locked <= 1'b0;
        end else begin
            raw_d      <= in_raw;
            sym        <= sym_next;
            out_locked <= (state == LOCKED);
            if (is_ctrl) begin
                out_de   <= 1'b0;
                out_c    <= ctrl_val;
                out_data <= '0;
            end else begin
                out_de   <= 1'b1;
                out_data <= dec;
            end
        end
    end

    assign out_offset = offset;

endmodule

// File: tb/tb_dvid2vga_channel.sv
// Bench for dvid2vga_channel: randomized TMDS line streams at chosen symbol boundaries,
// checked cycle by cycle against a bit-level reference model through a scoreboard queue.
module tb_dvid2vga_channel;

    localparam int LOCK_RUN   = 16;
    localparam int SEARCH_CYC = 1024;
    localparam int LINE_CTRL  = 160;
    localparam int LINE_LEN   = 800;

    logic       clk_pixel = 1'b0;
    logic       reset     = 1'b1;
    logic [9:0] in_raw    = '0;
    logic [7:0] out_data;
    logic [1:0] out_c;
    logic       out_de;
    logic       out_locked;
    logic [3:0] out_offset;

    always #5 clk_pixel = ~clk_pixel;

    dvid2vga_channel #(
        .C_lock_run      (LOCK_RUN),
        .C_search_cycles (SEARCH_CYC)
    ) dut (
        .clk_pixel  (clk_pixel),
        .reset      (reset),
        .in_raw     (in_raw),
        .out_data   (out_data),
        .out_c      (out_c),
        .out_de     (out_de),
        .out_locked (out_locked),
        .out_offset (out_offset)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] c;
        logic       de;
        logic       locked;
        logic [3:0] offset;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, kept as plain integers and bit vectors.
    logic [9:0] m_prev;
    logic [9:0] m_sym;
    int         m_off;
    int         m_run;
    int         m_timer;
    bit         m_lock;
    exp_t       m_out;

    // Serial bit stream and line generator state.
    bit         bq[$];
    int         line_pos = 0;
    int         line_tok = 0;
    logic [9:0] tokens[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    function automatic int token_code(input logic [9:0] s);
        case (s)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] decode_data(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] x;
        d    = s[9] ? ~s[7:0] : s[7:0];
        x    = d ^ {d[6:0], 1'b0};
        x    = s[8] ? x : ~x;
        x[0] = d[0];
        return x;
    endfunction

    task automatic model_reset();
        m_prev  = '0;
        m_sym   = '0;
        m_off   = 0;
        m_run   = 0;
        m_timer = 0;
        m_lock  = 1'b0;
        m_out   = '0;
    endtask

    task automatic model_step(input logic [9:0] w);
        logic [19:0] h;
        logic [9:0]  nsym;
        int          tok;
        int          run_next;
        bit          was_lock;
        h        = {w, m_prev};
        nsym     = 10'(h >> m_off);
        tok      = token_code(m_sym);
        was_lock = m_lock;
        run_next = (tok >= 0) ? ((m_run + 1 > LOCK_RUN) ? LOCK_RUN : m_run + 1) : 0;
        if (tok >= 0) begin
            m_out.de   = 1'b0;
            m_out.c    = 2'(tok);
            m_out.data = '0;
        end else begin
            m_out.de   = 1'b1;
            m_out.data = decode_data(m_sym);
        end
        if (!m_lock) begin
            if (run_next == LOCK_RUN) begin
                m_lock  = 1'b1;
                m_timer = 0;
                m_run   = run_next;
            end else if (m_timer == SEARCH_CYC - 1) begin
                m_off   = (m_off == 9) ? 0 : m_off + 1;
                m_timer = 0;
                m_run   = 0;
            end else begin
                m_timer = m_timer + 1;
                m_run   = run_next;
            end
        end else begin
            m_run = run_next;
            if (tok >= 0) begin
                m_timer = 0;
            end else if (m_timer == SEARCH_CYC - 1) begin
                m_lock  = 1'b0;
                m_off   = (m_off == 9) ? 0 : m_off + 1;
                m_run   = 0;
                m_timer = 0;
            end else begin
                m_timer = m_timer + 1;
            end
        end
        m_out.locked = was_lock;
        m_out.offset = 4'(m_off);
        m_sym        = nsym;
        m_prev       = w;
    endtask

    // One clock of stimulus: drive on the falling edge and queue the expected outputs.
    task automatic drive(input logic [9:0] w, input bit rst);
        @(negedge clk_pixel);
        reset  = rst;
        in_raw = w;
        if (rst) model_reset();
        else     model_step(w);
        exp_q.push_back(m_out);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    task automatic rand_data(output logic [9:0] s);
        do s = 10'($urandom_range(0, 1023)); while (token_code(s) >= 0);
    endtask

    task automatic next_symbol(output logic [9:0] s);
        if (line_pos == 0) line_tok = $urandom_range(0, 3);
        if (line_pos < LINE_CTRL) s = tokens[line_tok];
        else rand_data(s);
        line_pos = (line_pos + 1) % LINE_LEN;
    endtask

    task automatic stream_step(input logic [9:0] s);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) bq.push_back(s[i]);
        for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
        drive(w, 1'b0);
    endtask

    // Restart the serial stream so symbols begin at bit k of a word.
    task automatic set_boundary(input int k);
        bq.delete();
        for (int i = 0; i < k; i++) bq.push_back(1'b0);
    endtask

    task automatic run_stream(input int max_cycles, input int want_off, input string name);
        logic [9:0] s;
        int         extra;
        extra = 0;
        for (int i = 0; i < max_cycles && extra < 4; i++) begin
            next_symbol(s);
            stream_step(s);
            if (m_lock && m_off == want_off) extra++;
        end
        @(posedge clk_pixel); #2;
        check({name, "_locked"}, int'(out_locked), 1);
        check({name, "_offset"}, int'(out_offset), want_off);
    endtask

    task automatic wait_unlock(input int max_cycles, input int want_off, input bit use_data,
                               input string name);
        logic [9:0] s;
        int         extra;
        extra = 0;
        for (int i = 0; i < max_cycles && extra < 3; i++) begin
            if (use_data) begin
                rand_data(s);
                stream_step(s);
            end else begin
                drive(10'h000, 1'b0);
            end
            if (!m_lock) extra++;
        end
        @(posedge clk_pixel); #2;
        check({name, "_locked"}, int'(out_locked), 0);
        check({name, "_offset"}, int'(out_offset), want_off);
    endtask

    // Scoreboard monitor: one expected entry per clock edge.
    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk_pixel); #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{data: out_data, c: out_c, de: out_de, locked: out_locked,
                        offset: out_offset};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL scoreboard @%0t: got data=%h c=%b de=%b locked=%b off=%0d, expected data=%h c=%b de=%b locked=%b off=%0d",
                             $time, got.data, got.c, got.de, got.locked, got.offset,
                             e.data, e.c, e.de, e.locked, e.offset);
                end
            end
        end
    end

    initial begin : stimulus
        logic [9:0] s;
        model_reset();
        repeat (3) drive(10'h000, 1'b1);
        @(posedge clk_pixel); #2;
        check("reset_data", int'(out_data), 0);
        check("reset_c", int'(out_c), 0);
        check("reset_de", int'(out_de), 0);
        check("reset_locked", int'(out_locked), 0);
        check("reset_offset", int'(out_offset), 0);

        // Aligned tokens, then known data symbols.
        for (int i = 0; i < 20; i++) drive(10'h354, 1'b0);
        @(posedge clk_pixel); #2;
        check("t1_locked", int'(out_locked), 1);
        check("t1_offset", int'(out_offset), 0);
        check("t1_c", int'(out_c), 0);
        check("t1_de", int'(out_de), 0);
        drive(10'h1FF, 1'b0);
        drive(10'h2FF, 1'b0);
        drive(10'h2AB, 1'b0);
        @(posedge clk_pixel); #2;
        check("t1_data_1ff", int'(out_data), 8'h01);
        check("t1_de_1ff", int'(out_de), 1);
        drive(10'h354, 1'b0);
        @(posedge clk_pixel); #2;
        check("t1_data_2ff", int'(out_data), 8'hFE);
        drive(10'h354, 1'b0);
        @(posedge clk_pixel); #2;
        check("t1_c_2ab", int'(out_c), 3);
        check("t1_de_2ab", int'(out_de), 0);

        // Boundary 7 from a fresh search at offset 0.
        repeat (2) drive(10'h000, 1'b1);
        set_boundary(7);
        run_stream(12000, 7, "t2");

        // Walk to offset 9, then wrap through 0 to boundary 3.
        wait_unlock(3000, 8, 1'b0, "t3_unlock7");
        set_boundary(9);
        run_stream(4000, 9, "t3_lock9");
        wait_unlock(3000, 0, 1'b0, "t3_wrap");
        set_boundary(3);
        run_stream(6000, 3, "t3_lock3");

        // Aligned data only: watchdog drops lock and slips once.
        wait_unlock(3000, 4, 1'b1, "t4");

        // Sixteenth token arrives on the exact timeout cycle.
        set_boundary(4);
        for (int i = 0; i < 3000 && m_timer != SEARCH_CYC - 18; i++) begin
            rand_data(s);
            stream_step(s);
        end
        for (int i = 0; i < 22; i++) stream_step(10'h154);
        @(posedge clk_pixel); #2;
        check("t5_locked", int'(out_locked), 1);
        check("t5_offset", int'(out_offset), 4);

        // Lock at offset 5, then async reset mid-line.
        wait_unlock(3000, 5, 1'b0, "t6_unlock4");
        set_boundary(5);
        run_stream(4000, 5, "t6_lock5");
        for (int i = 0; i < 300; i++) begin
            next_symbol(s);
            stream_step(s);
        end
        @(posedge clk_pixel); #3;
        reset = 1'b1;
        #1;
        check("t6_async_data", int'(out_data), 0);
        check("t6_async_c", int'(out_c), 0);
        check("t6_async_de", int'(out_de), 0);
        check("t6_async_locked", int'(out_locked), 0);
        check("t6_async_offset", int'(out_offset), 0);
        model_reset();
        repeat (3) drive(10'h000, 1'b1);
        run_stream(9000, 5, "t6_relock");

        repeat (2) @(posedge clk_pixel);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
